// File: rtl/mlp_param_loader.sv
// rtl/mlp_param_loader.sv - streams MLP weights and biases into parameter-memory write strobes
//
// Purpose:
//   Accepts a stream of signed parameter words and turns each accepted word
//   into one registered memory write. The order is: layer 0..M-2, then
//   neuron 0..N-1, then N weights followed by one bias per neuron.
//
// Ports:
//   i_clk        clock; all logic is rising-edge triggered
//   i_rst        synchronous active-high reset
//   i_start      one-cycle request to begin a full load (ignored while busy)
//   i_s_valid    a word is present on i_s_data
//   i_s_data     signed weight or bias word, DW bits
//   o_s_ready    the loader accepts i_s_data this cycle (LOAD state only)
//   o_wr_en      parameter-memory write strobe, one cycle after a handshake
//   o_wr_layer   target layer index
//   o_wr_neuron  target neuron index
//   o_wr_idx     target weight index; 0 for a bias write
//   o_wr_is_bias the write targets the bias of o_wr_layer/o_wr_neuron
//   o_wr_data    word to write
//   o_busy       high in LOAD and DONE
//   o_done       one-cycle pulse alongside the final write

module mlp_param_loader #(
  parameter  int M  = 2,
  parameter  int N  = 2,
  parameter  int QM = 3,
  parameter  int QN = 5,
  parameter  int WM = 3,
  parameter  int WN = 5,
  localparam int DW = WM + WN,
  localparam int LW = (M > 2) ? $clog2(M - 1) : 1,
  localparam int NW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_s_valid,
  input  logic [DW-1:0] i_s_data,
  output logic          o_s_ready,
  output logic          o_wr_en,
  output logic [LW-1:0] o_wr_layer,
  output logic [NW-1:0] o_wr_neuron,
  output logic [NW-1:0] o_wr_idx,
  output logic          o_wr_is_bias,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic          o_done
);

  // Bias and weight words share one data path, so their widths must agree.
  if (WM + WN != QM + QN) begin : g_width_check
    $error("mlp_param_loader: WM+WN must equal QM+QN");
  end

  // The index counter needs one extra code beyond N-1 to mark the bias slot.
  localparam int IW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LW-1:0] LAST_LAYER  = LW'(M - 2);
  localparam logic [NW-1:0] LAST_NEURON = NW'(N - 1);
  localparam logic [IW-1:0] BIAS_IDX    = IW'(N);

  logic [1:0]    r_state;
  logic [LW-1:0] r_layer;
  logic [NW-1:0] r_neuron;
  logic [IW-1:0] r_idx;

  logic          r_wr_en;
  logic [LW-1:0] r_wr_layer;
  logic [NW-1:0] r_wr_neuron;
  logic [NW-1:0] r_wr_idx;
  logic          r_wr_is_bias;
  logic [DW-1:0] r_wr_data;

  logic w_hs;
  logic w_at_bias;
  logic w_neuron_end;
  logic w_layer_end;
  logic w_last;

  // s_ready is high only in LOAD, so s_valid in IDLE/DONE never counts.
  assign w_hs         = (r_state == S_LOAD) && i_s_valid;
  assign w_at_bias    = (r_idx == BIAS_IDX);
  assign w_neuron_end = (r_neuron == LAST_NEURON);
  assign w_layer_end  = (r_layer == LAST_LAYER);
  assign w_last       = w_hs && w_at_bias && w_neuron_end && w_layer_end;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_layer      <= '0;
      r_neuron     <= '0;
      r_idx        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_layer   <= '0;
      r_wr_neuron  <= '0;
      r_wr_idx     <= '0;
      r_wr_is_bias <= 1'b0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= w_hs;

      // Write address/data only update on a handshake so they hold otherwise.
      if (w_hs) begin
        r_wr_data    <= i_s_data;
        r_wr_layer   <= r_layer;
        r_wr_neuron  <= r_neuron;
        r_wr_idx     <= w_at_bias ? '0 : r_idx[NW-1:0];
        r_wr_is_bias <= w_at_bias;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_LOAD;
            r_layer  <= '0;
            r_neuron <= '0;
            r_idx    <= '0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            if (w_at_bias) begin
              r_idx <= '0;
              if (w_neuron_end) begin
                r_neuron <= '0;
                r_layer  <= w_layer_end ? '0 : r_layer + LW'(1);
              end else begin
                r_neuron <= r_neuron + NW'(1);
              end
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_s_ready    = (r_state == S_LOAD);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_wr_en      = r_wr_en;
  assign o_wr_layer   = r_wr_layer;
  assign o_wr_neuron  = r_wr_neuron;
  assign o_wr_idx     = r_wr_idx;
  assign o_wr_is_bias = r_wr_is_bias;
  assign o_wr_data    = r_wr_data;

endmodule

// File: tb/tb_mlp_param_loader.sv
// tb/tb_mlp_param_loader.sv - directed self-checking bench for mlp_param_loader

module tb_mlp_param_loader;

  logic       clk = 1'b0;
  logic       rst;

  // M=2, N=2 instance
  logic       start, s_valid;
  logic [7:0] s_data;
  logic       s_ready, wr_en, wr_is_bias, busy, done;
  logic [0:0] wr_layer, wr_neuron, wr_idx;
  logic [7:0] wr_data;

  // M=3, N=2 instance
  logic       start3, s_valid3;
  logic [7:0] s_data3;
  logic       s_ready3, wr_en3, wr_is_bias3, busy3, done3;
  logic [0:0] wr_layer3, wr_neuron3, wr_idx3;
  logic [7:0] wr_data3;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cnt;

  // Expected addresses for the six writes of one N=2 layer.
  int exp_n [6] = '{0, 0, 0, 1, 1, 1};
  int exp_i [6] = '{0, 1, 0, 0, 1, 0};
  int exp_b [6] = '{0, 0, 1, 0, 0, 1};
  logic [7:0] edge_words [6] = '{8'h80, 8'h7F, 8'h01, 8'hFE, 8'h40, 8'hC0};

  always #5 clk = ~clk;

  mlp_param_loader #(.M(2), .N(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_s_valid(s_valid), .i_s_data(s_data),
    .o_s_ready(s_ready), .o_wr_en(wr_en), .o_wr_layer(wr_layer), .o_wr_neuron(wr_neuron),
    .o_wr_idx(wr_idx), .o_wr_is_bias(wr_is_bias), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done)
  );

  mlp_param_loader #(.M(3), .N(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_s_valid(s_valid3), .i_s_data(s_data3),
    .o_s_ready(s_ready3), .o_wr_en(wr_en3), .o_wr_layer(wr_layer3), .o_wr_neuron(wr_neuron3),
    .o_wr_idx(wr_idx3), .o_wr_is_bias(wr_is_bias3), .o_wr_data(wr_data3),
    .o_busy(busy3), .o_done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [7:0] d);
    chk({tag, " wr_en"},      32'(wr_en), 32'd1);
    chk({tag, " wr_layer"},   32'(wr_layer), 32'd0);
    chk({tag, " wr_neuron"},  32'(wr_neuron), 32'(exp_n[k]));
    chk({tag, " wr_idx"},     32'(wr_idx), 32'(exp_i[k]));
    chk({tag, " wr_is_bias"}, 32'(wr_is_bias), 32'(exp_b[k]));
    chk({tag, " wr_data"},    32'(wr_data), 32'(d));
    chk({tag, " done"},       32'(done), (k == 5) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " s_ready"},    32'(s_ready), 32'd0);
    chk({tag, " wr_en"},      32'(wr_en), 32'd0);
    chk({tag, " done"},       32'(done), 32'd0);
    chk({tag, " busy"},       32'(busy), 32'd0);
    chk({tag, " wr_is_bias"}, 32'(wr_is_bias), 32'd0);
    chk({tag, " wr_layer"},   32'(wr_layer), 32'd0);
    chk({tag, " wr_neuron"},  32'(wr_neuron), 32'd0);
    chk({tag, " wr_idx"},     32'(wr_idx), 32'd0);
    chk({tag, " wr_data"},    32'(wr_data), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    start3 = 1'b0; s_valid3 = 1'b0; s_data3 = 8'h00;
    tick(); tick();
    chk_zero("reset");
    chk("reset busy3", 32'(busy3), 32'd0);
    chk("reset s_ready3", 32'(s_ready3), 32'd0);

    // s_valid in IDLE is ignored
    rst = 1'b0; s_valid = 1'b1; s_data = 8'h55;
    tick();
    chk("idle wr_en", 32'(wr_en), 32'd0);
    chk("idle s_ready", 32'(s_ready), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    s_valid = 1'b0;

    // back-to-back load 0x11..0x16
    start = 1'b1;
    tick();
    chk("start busy", 32'(busy), 32'd1);
    chk("start s_ready", 32'(s_ready), 32'd1);
    chk("start wr_en", 32'(wr_en), 32'd0);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_valid = 1'b1; s_data = 8'h11 + 8'(k);
      tick();
      chk_wr("b2b", k, 8'h11 + 8'(k));
    end
    chk("b2b done s_ready", 32'(s_ready), 32'd0);
    chk("b2b done busy", 32'(busy), 32'd1);
    s_valid = 1'b0;
    tick();
    chk("b2b after wr_en", 32'(wr_en), 32'd0);
    chk("b2b after done", 32'(done), 32'd0);
    chk("b2b after busy", 32'(busy), 32'd0);
    chk("b2b hold data", 32'(wr_data), 32'h16);
    chk("b2b hold bias", 32'(wr_is_bias), 32'd1);

    // s_valid toggling 1,0,1,0
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_valid = 1'b1; s_data = 8'h20 + 8'(k);
      tick();
      chk_wr("gap", k, 8'h20 + 8'(k));
      s_valid = 1'b0;
      tick();
      chk("gap wr_en", 32'(wr_en), 32'd0);
      chk("gap hold data", 32'(wr_data), 32'(8'h20 + 8'(k)));
      chk("gap busy", 32'(busy), (k == 5) ? 32'd0 : 32'd1);
    end

    // start pulsed mid-load must not reset the counters
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 8'h30 + 8'(k);
      tick();
      chk_wr("restart", k, 8'h30 + 8'(k));
    end
    s_valid = 1'b0; start = 1'b1;
    tick();
    chk("restart mid wr_en", 32'(wr_en), 32'd0);
    chk("restart mid busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int k = 3; k < 6; k++) begin
      s_valid = 1'b1; s_data = 8'h30 + 8'(k);
      tick();
      chk_wr("restart", k, 8'h30 + 8'(k));
    end
    s_valid = 1'b0;
    tick();

    // reset after the 4th handshake aborts the load
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_data = 8'h60 + 8'(k);
      tick();
      chk_wr("abort", k, 8'h60 + 8'(k));
    end
    rst = 1'b1; s_data = 8'h99;
    tick();
    chk_zero("abort rst");
    rst = 1'b0;
    tick();
    chk("abort idle wr_en", 32'(wr_en), 32'd0);
    chk("abort idle busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    chk("abort restart wr_en", 32'(wr_en), 32'd0);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_data = edge_words[k];
      tick();
      chk_wr("edge", k, edge_words[k]);
    end
    s_valid = 1'b0;
    tick();
    chk("edge after busy", 32'(busy), 32'd0);

    // M=3: second layer and busy length
    busy_cnt = 0;
    start3 = 1'b1;
    tick();
    if (busy3) busy_cnt++;
    start3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      s_valid3 = 1'b1; s_data3 = 8'h40 + 8'(k);
      tick();
      if (busy3) busy_cnt++;
      chk("m3 wr_en", 32'(wr_en3), 32'd1);
      chk("m3 wr_layer", 32'(wr_layer3), (k >= 6) ? 32'd1 : 32'd0);
      chk("m3 wr_neuron", 32'(wr_neuron3), 32'(exp_n[k % 6]));
      chk("m3 wr_idx", 32'(wr_idx3), 32'(exp_i[k % 6]));
      chk("m3 wr_is_bias", 32'(wr_is_bias3), 32'(exp_b[k % 6]));
      chk("m3 wr_data", 32'(wr_data3), 32'(8'h40 + 8'(k)));
      chk("m3 done", 32'(done3), (k == 11) ? 32'd1 : 32'd0);
    end
    s_valid3 = 1'b0;
    tick();
    if (busy3) busy_cnt++;
    chk("m3 busy cycles", 32'(busy_cnt), 32'd13);
    chk("m3 after wr_en", 32'(wr_en3), 32'd0);
    chk("m3 after done", 32'(done3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
